multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle ARM-subset CPU: decodes the fetched instruction, sequences it through a Moore state machine, and holds the NZCV flags. Condition evaluation gates every architectural write. It replaces the single-cycle controller when the datapath shares one memory and one ALU across cycles. It drives every datapath mux, enable and ALU-operation select.

## Interface
- ALUCTRL_W, 2: ALUControl width; legal values are 2 or 3. With 3, EOR and MOV are supported.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- Instr  in  20  Instr[31:12] from the instruction register: cond, op, funct, Rd.
- ALUFlags  in  4  NZCV from the ALU, current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = Rm/shifted, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  immediate select; equals Instr[25:24].
- RegSrc  out  2  register address select, as in the single-cycle encoding.
- ALUControl  out  ALUCTRL_W  00 = ADD, 01 = SUB, 10 = AND, 11 = ORR. With width 3: 100 = EOR, 101 = MOV (pass B).

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNDEF.
- **Transitions from FETCH and DECODE:**
  - FETCH→DECODE, always.
  - DECODE→MEMADR when op = 01.
  - DECODE→EXECR when op = 00 and I = 0.
  - DECODE→EXECI when op = 00 and I = 1.
  - DECODE→BRANCH when op = 10.
  - DECODE→UNDEF when op = 11, or when the command is unsupported at the configured ALUCTRL_W.
- **Later transitions:**
  - MEMADR→MEMRD when L = 1; MEMADR→MEMWR when L = 0.
  - MEMRD→MEMWB.
  - EXECR and EXECI → ALUWB, or → FETCH when the instruction has NoWrite set.
  - MEMWB, MEMWR, ALUWB, BRANCH and UNDEF → FETCH.
- **Per-state outputs:**
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ADD, ResultSrc = 10, PCWrite = 1 (unconditional).
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, ADD, ResultSrc = 10.
  - MEMADR: ALUSrcA = 0, ALUSrcB = 01, ADD, with U = 0 selecting SUB.
  - MEMRD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegW.
  - MEMWR: AdrSrc = 1, MemW.
  - EXECR: ALUSrcB = 00, decoded operation.
  - EXECI: ALUSrcB = 01, decoded operation.
  - ALUWB: ResultSrc = 00, RegW.
  - BRANCH: ALUSrcA = 0, ALUSrcB = 01, ADD, ResultSrc = 10, Branch.
  - UNDEF: all write enables 0.
- **Condition evaluation:** CondEx is evaluated in DECODE from the stored flags against Instr[31:28], using the standard 15 codes (1110 = always), and latched into cond_q.
  - Write gating: RegWrite = RegW & cond_q & ~PCS; MemWrite = MemW & cond_q.
  - PCS = Branch | (RegW & Rd = 15).
  - PCWrite = (state == FETCH) | (PCS & cond_q). A PC write therefore replaces the register write when Rd = 15.
- **Flags:**
  - Updated at the end of EXECR/EXECI only when S = 1 and cond_q = 1.
  - N and Z update for every command.
  - C and V update only for ADD and SUB; they hold for the logical commands and MOV.
- **NoWrite:** set for CMP; the instruction then retires from EXEC directly to FETCH.

## Timing
- Reset values: state = FETCH, flags = 0000, cond_q = 0. Outputs take the FETCH values combinationally, so PCWrite = 1 and IRWrite = 1 during reset.
- An asynchronous reset mid-instruction aborts it; no partial write occurs after reset deassertion.
- Latency in cycles:
  - B: 3.
  - Data-processing: 4; CMP: 3.
  - STR: 4; LDR: 5.
  - Undefined instruction: 3.
- A failed condition still consumes the full state sequence with writes suppressed, except that CMP exits after EXEC.
- Flags written in EXEC are visible to the next instruction's DECODE; there is no same-instruction hazard.

## Configuration
- MCTRL_CMP_EN defined: cmd 1010 decodes as CMP, i.e. SUB with NoWrite = 1 and S forced to 1.
- MCTRL_CMP_EN undefined: cmd 1010 goes to UNDEF, and flags are unchanged.

## Structure
- mctrl_pkg holds:
  - the state enum;
  - the ALU operation localparams (including the 3-bit codes);
  - the ResultSrc and ALUSrcB encodings;
  - the cond-code constants.
- Sub-module mctrl_condlogic holds the flag register, the condition evaluator, cond_q and write gating.
- The FSM and the decoder stay in the top module.

## Test plan
- Reset asserted in EXECR, then released → state = FETCH, no RegWrite pulse, flags = 0000.
- SUBS with ALUFlags = 0110 → 4 cycles, flags = 0110. A following BEQ (cond 0000) → PCWrite in BRANCH; BNE → no PCWrite in BRANCH.
- LDR R1,[R2,#4] → 5 cycles, AdrSrc = 1 in MEMRD, RegWrite only in MEMWB with ResultSrc = 01.
- ADD with Rd = 15 → PCWrite = 1 and RegWrite = 0 in ALUWB.
- CMP with MCTRL_CMP_EN defined → 3 cycles, ALUControl = 01, no RegWrite. With the macro undefined → UNDEF, flags unchanged.
- ALUCTRL_W = 3, EOR → ALUControl = 100. ALUCTRL_W = 2, EOR → UNDEF, no writes.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, ALU operation codes, mux encodings and condition codes.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_UNDEF
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // nzcv is {N, Z, C, V}; the reserved code 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mctrl_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// mux selects, enables and ALU operation out.
interface mctrl_if #(
  parameter int unsigned ALUCTRL_W = 2
);
  logic [19:0]          Instr;
  logic [3:0]           ALUFlags;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [1:0]           RegSrc;
  logic [ALUCTRL_W-1:0] ALUControl;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/mctrl_condlogic.sv
// NZCV flag register, condition evaluation latched as cond_q in DECODE,
// and the gating of PC, register-file and memory writes.
module mctrl_condlogic
  import mctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_cond_latch,
  input  logic       i_flag_w_nz,
  input  logic       i_flag_w_cv,
  input  logic       i_fetch,
  input  logic       i_branch,
  input  logic       i_regw,
  input  logic       i_memw,
  input  logic       i_rd_pc,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_mem_write
);

  logic [3:0] r_flags;
  logic       r_cond_q;
  logic       w_pcs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags  <= '0;
      r_cond_q <= 1'b0;
    end else begin
      if (i_cond_latch) r_cond_q <= cond_eval(i_cond, r_flags);
      if (i_flag_w_nz & r_cond_q) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_flag_w_cv & r_cond_q) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  // A write to R15 is a PC write, so it displaces the register write.
  always_comb begin
    w_pcs       = i_branch | (i_regw & i_rd_pc);
    o_pc_write  = i_fetch | (w_pcs & r_cond_q);
    o_reg_write = i_regw & r_cond_q & ~w_pcs;
    o_mem_write = i_memw & r_cond_q;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: instruction decoder and Moore FSM.
// Define MCTRL_CMP_EN to decode cmd 1010 as CMP; otherwise it is undefined.
module multicycle_controller
  import mctrl_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 2
) (
  input  logic      clk,
  input  logic      reset,
  mctrl_if.master   bus
);

  localparam bit EXT_OPS = (ALUCTRL_W >= 3);

  state_t r_state, w_next;

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic [3:0] w_cmd;
  logic       w_unused_rn;

  logic [2:0] w_dp_op;
  logic       w_dp_ok;
  logic       w_arith;
  logic       w_nowrite;
  logic       w_flag_s;

  logic       w_irwrite;
  logic       w_adrsrc;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic [2:0] w_aluop;
  logic       w_fetch;
  logic       w_branch;
  logic       w_regw;
  logic       w_memw;
  logic       w_cond_latch;
  logic       w_flag_nz;
  logic       w_flag_cv;

  assign w_cond      = bus.Instr[19:16];
  assign w_op        = bus.Instr[15:14];
  assign w_funct     = bus.Instr[13:8];
  assign w_rd        = bus.Instr[3:0];
  assign w_cmd       = w_funct[4:1];
  assign w_unused_rn = ^bus.Instr[7:4];

  always_comb begin
    w_dp_op   = ALU_ADD;
    w_dp_ok   = 1'b1;
    w_arith   = 1'b0;
    w_nowrite = 1'b0;
    case (w_cmd)
      CMD_ADD: begin w_dp_op = ALU_ADD; w_arith = 1'b1; end
      CMD_SUB: begin w_dp_op = ALU_SUB; w_arith = 1'b1; end
      CMD_AND: w_dp_op = ALU_AND;
      CMD_ORR: w_dp_op = ALU_ORR;
      CMD_EOR: begin w_dp_op = ALU_EOR; w_dp_ok = EXT_OPS; end
      CMD_MOV: begin w_dp_op = ALU_MOV; w_dp_ok = EXT_OPS; end
      CMD_CMP: begin
`ifdef MCTRL_CMP_EN
        w_dp_op   = ALU_SUB;
        w_arith   = 1'b1;
        w_nowrite = 1'b1;
`else
        w_dp_ok   = 1'b0;
`endif
      end
      default: w_dp_ok = 1'b0;
    endcase
    w_flag_s = w_funct[0] | w_nowrite;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_irwrite    = 1'b0;
    w_adrsrc     = 1'b0;
    w_alusrca    = 1'b0;
    w_alusrcb    = SRCB_REG;
    w_resultsrc  = RES_ALUOUT;
    w_aluop      = ALU_ADD;
    w_fetch      = 1'b0;
    w_branch     = 1'b0;
    w_regw       = 1'b0;
    w_memw       = 1'b0;
    w_cond_latch = 1'b0;
    w_flag_nz    = 1'b0;
    w_flag_cv    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next      = S_DECODE;
        w_irwrite   = 1'b1;
        w_alusrca   = 1'b1;
        w_alusrcb   = SRCB_FOUR;
        w_resultsrc = RES_ALURESULT;
        w_fetch     = 1'b1;
      end
      S_DECODE: begin
        w_alusrca    = 1'b1;
        w_alusrcb    = SRCB_FOUR;
        w_resultsrc  = RES_ALURESULT;
        w_cond_latch = 1'b1;
        case (w_op)
          2'b00:   w_next = !w_dp_ok ? S_UNDEF : (w_funct[5] ? S_EXECI : S_EXECR);
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_UNDEF;
        endcase
      end
      S_MEMADR: begin
        w_alusrcb = SRCB_IMM;
        w_aluop   = w_funct[3] ? ALU_ADD : ALU_SUB;
        w_next    = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = RES_DATA;
        w_regw      = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWR: begin
        w_adrsrc = 1'b1;
        w_memw   = 1'b1;
        w_next   = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        w_alusrcb = (r_state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        w_aluop   = w_dp_op;
        w_flag_nz = w_flag_s;
        w_flag_cv = w_flag_s & w_arith;
        w_next    = w_nowrite ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        w_resultsrc = RES_ALUOUT;
        w_regw      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrcb   = SRCB_IMM;
        w_resultsrc = RES_ALURESULT;
        w_branch    = 1'b1;
        w_next      = S_FETCH;
      end
      S_UNDEF: w_next = S_FETCH;
      default: w_next = S_FETCH;
    endcase
  end

  mctrl_condlogic u_cond (
    .clk          (clk),
    .reset        (reset),
    .i_cond       (w_cond),
    .i_alu_flags  (bus.ALUFlags),
    .i_cond_latch (w_cond_latch),
    .i_flag_w_nz  (w_flag_nz),
    .i_flag_w_cv  (w_flag_cv),
    .i_fetch      (w_fetch),
    .i_branch     (w_branch),
    .i_regw       (w_regw),
    .i_memw       (w_memw),
    .i_rd_pc      (w_rd == 4'hF),
    .o_pc_write   (bus.PCWrite),
    .o_reg_write  (bus.RegWrite),
    .o_mem_write  (bus.MemWrite)
  );

  assign bus.IRWrite    = w_irwrite;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.ResultSrc  = w_resultsrc;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUControl = w_aluop[ALUCTRL_W-1:0];
  assign bus.ImmSrc     = w_funct[5:4];
  assign bus.RegSrc     = {w_op == 2'b01, w_op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: one instance at ALUCTRL_W = 2 and one at 3,
// each checked cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic [2:0] alu;
  } exp_t;

`ifdef MCTRL_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  localparam logic [19:0] IDLE = 20'hEC000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mctrl_if #(.ALUCTRL_W(2)) bus2 ();
  mctrl_if #(.ALUCTRL_W(3)) bus3 ();

  multicycle_controller #(.ALUCTRL_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));
  multicycle_controller #(.ALUCTRL_W(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.master));

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [3:0]  mflags [2];

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                     input logic [5:0] fn, input logic [3:0] rd);
    logic [3:0] rn;
    rn = 4'($urandom);
    return {cond, op, fn, rn, rd};
  endfunction

  function automatic exp_t base_exp(input logic [19:0] ins);
    exp_t e;
    e = '0;
    e.imm    = ins[13:12];
    e.regsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
    return e;
  endfunction

  function automatic exp_t fetch_exp(input logic [19:0] ins);
    exp_t e;
    e      = base_exp(ins);
    e.pcw  = 1'b1;
    e.irw  = 1'b1;
    e.srca = 1'b1;
    e.srcb = 2'b10;
    e.res  = 2'b10;
    return e;
  endfunction

  function automatic exp_t get_obs(input int sel);
    exp_t o;
    if (sel == 0)
      o = {bus2.PCWrite, bus2.AdrSrc, bus2.MemWrite, bus2.IRWrite, bus2.RegWrite, bus2.ResultSrc,
           bus2.ALUSrcA, bus2.ALUSrcB, bus2.ImmSrc, bus2.RegSrc, {1'b0, bus2.ALUControl}};
    else
      o = {bus3.PCWrite, bus3.AdrSrc, bus3.MemWrite, bus3.IRWrite, bus3.RegWrite, bus3.ResultSrc,
           bus3.ALUSrcA, bus3.ALUSrcB, bus3.ImmSrc, bus3.RegSrc, bus3.ALUControl};
    return o;
  endfunction

  function automatic logic [3:0] get_flags(input int sel);
    return (sel == 0) ? dut2.u_cond.r_flags : dut3.u_cond.r_flags;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [19:0] ins, input logic [3:0] af);
    if (sel == 0) begin bus2.Instr = ins; bus2.ALUFlags = af; end
    else          begin bus3.Instr = ins; bus3.ALUFlags = af; end
  endtask

  // Called #1 after the edge that enters FETCH; returns #1 after the next FETCH edge.
  task automatic run_instr(input int sel, input string name, input logic [19:0] ins,
                           input logic [3:0] af_exec);
    logic [3:0] cond, rd, af;
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] code;
    logic       c;
    bit         ok, arith, nowr;
    int         exec_idx;
    exp_t       q[$];
    exp_t       b, e;
    cond = ins[19:16]; op = ins[15:14]; fn = ins[13:8]; rd = ins[3:0];
    c = cond_true(cond, mflags[sel]);
    b = base_exp(ins);
    q.push_back(fetch_exp(ins));
    e = b; e.srca = 1'b1; e.srcb = 2'b10; e.res = 2'b10; q.push_back(e);
    exec_idx = -1; arith = 0; nowr = 0; ok = 1; code = 3'd0;
    case (op)
      2'b01: begin
        e = b; e.srcb = 2'b01; e.alu = fn[3] ? 3'd0 : 3'd1; q.push_back(e);
        if (fn[0]) begin
          e = b; e.adr = 1'b1; q.push_back(e);
          e = b; e.res = 2'b01; e.pcw = c && rd == 4'hF; e.regw = c && rd != 4'hF; q.push_back(e);
        end else begin
          e = b; e.adr = 1'b1; e.memw = c; q.push_back(e);
        end
      end
      2'b10: begin
        e = b; e.srcb = 2'b01; e.res = 2'b10; e.pcw = c; q.push_back(e);
      end
      2'b00: begin
        case (fn[4:1])
          4'b0100: begin code = 3'd0; arith = 1; end
          4'b0010: begin code = 3'd1; arith = 1; end
          4'b0000: code = 3'd2;
          4'b1100: code = 3'd3;
          4'b0001: begin code = 3'd4; ok = (sel == 1); end
          4'b1101: begin code = 3'd5; ok = (sel == 1); end
          4'b1010: begin code = 3'd1; arith = 1; nowr = 1; ok = CMP_EN; end
          default: ok = 0;
        endcase
        if (!ok) q.push_back(b);
        else begin
          e = b; e.srcb = fn[5] ? 2'b01 : 2'b00; e.alu = code;
          exec_idx = q.size(); q.push_back(e);
          if (!nowr) begin
            e = b; e.res = 2'b00; e.pcw = c && rd == 4'hF; e.regw = c && rd != 4'hF; q.push_back(e);
          end
        end
      end
      default: q.push_back(b);
    endcase
    foreach (q[i]) begin
      af = (i == exec_idx) ? af_exec : 4'($urandom);
      drive(sel, ins, af);
      @(negedge clk);
      check($sformatf("%s w%0d cyc%0d", name, sel + 2, i), 32'(get_obs(sel)), 32'(q[i]));
      @(posedge clk);
      #1;
    end
    if (exec_idx >= 0 && (fn[0] || nowr) && c) begin
      mflags[sel][3:2] = af_exec[3:2];
      if (arith) mflags[sel][1:0] = af_exec[1:0];
    end
    check($sformatf("%s w%0d flags", name, sel + 2), 32'(get_flags(sel)), 32'(mflags[sel]));
  endtask

  function automatic logic [19:0] rnd_instr();
    logic [3:0] cond, rd, cmd;
    logic [1:0] op;
    logic [5:0] fn;
    int unsigned k;
    cond = 4'($urandom_range(0, 14));
    rd   = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    k    = $urandom_range(0, 9);
    op   = (k < 5) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
    fn   = 6'($urandom);
    if (op == 2'b00) begin
      case ($urandom_range(0, 7))
        0: cmd = 4'b0100;
        1: cmd = 4'b0010;
        2: cmd = 4'b0000;
        3: cmd = 4'b1100;
        4: cmd = 4'b0001;
        5: cmd = 4'b1101;
        6: cmd = 4'b1010;
        default: cmd = 4'($urandom);
      endcase
      fn[4:1] = cmd;
    end
    return mk(cond, op, fn, rd);
  endfunction

  initial begin
    logic [19:0] ins;
    reset = 1'b1;
    drive(0, IDLE, 4'h0);
    drive(1, IDLE, 4'h0);
    mflags[0] = 4'h0;
    mflags[1] = 4'h0;
    #2;
    check("reset outputs w2", 32'(get_obs(0)), 32'(fetch_exp(IDLE)));
    check("reset outputs w3", 32'(get_obs(1)), 32'(fetch_exp(IDLE)));
    check("reset flags w2", 32'(get_flags(0)), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Phase 1: ALUCTRL_W = 2 instance
    run_instr(0, "SUBS",  mk(4'hE, 2'b00, 6'b000101, 4'h1), 4'b0110);
    run_instr(0, "BEQ",   mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0);
    run_instr(0, "BNE",   mk(4'h1, 2'b10, 6'b100000, 4'h0), 4'h0);
    run_instr(0, "LDR",   mk(4'hE, 2'b01, 6'b011001, 4'h1), 4'h0);
    run_instr(0, "STRsub",mk(4'hE, 2'b01, 6'b010000, 4'h3), 4'h0);
    run_instr(0, "ADDpc", mk(4'hE, 2'b00, 6'b101000, 4'hF), 4'h0);
    run_instr(0, "ADDNE", mk(4'h1, 2'b00, 6'b001001, 4'h2), 4'b1001);
    run_instr(0, "CMP",   mk(4'hE, 2'b00, 6'b010101, 4'h0), 4'b1000);
    run_instr(0, "EOR",   mk(4'hE, 2'b00, 6'b000011, 4'h4), 4'b1111);
    run_instr(0, "ORRS",  mk(4'hE, 2'b00, 6'b111001, 4'h5), 4'b1011);

    // Asynchronous reset during EXECR of an ADD: no write may follow.
    ins = mk(4'hE, 2'b00, 6'b001000, 4'h6);
    drive(0, ins, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    check("reset mid-EXECR outputs", 32'(get_obs(0)), 32'(fetch_exp(ins)));
    check("reset mid-EXECR flags", 32'(get_flags(0)), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mflags[0] = 4'h0;
    mflags[1] = 4'h0;
    run_instr(0, "BEQ after reset", mk(4'h0, 2'b10, 6'b100000, 4'h0), 4'h0);

    for (int i = 0; i < 120; i++)
      run_instr(0, $sformatf("rnd%0d", i), rnd_instr(), 4'($urandom));

    // Phase 2: ALUCTRL_W = 3 instance
    drive(0, IDLE, 4'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mflags[0] = 4'h0;
    mflags[1] = 4'h0;
    run_instr(1, "EORS",  mk(4'hE, 2'b00, 6'b000011, 4'h4), 4'b1111);
    run_instr(1, "MOVI",  mk(4'hE, 2'b00, 6'b111010, 4'h7), 4'h0);
    run_instr(1, "ADDS",  mk(4'hE, 2'b00, 6'b001001, 4'h1), 4'b0011);
    run_instr(1, "CMP",   mk(4'hE, 2'b00, 6'b010101, 4'h0), 4'b0100);
    run_instr(1, "BGT",   mk(4'hC, 2'b10, 6'b100000, 4'h0), 4'h0);
    for (int i = 0; i < 120; i++)
      run_instr(1, $sformatf("rnd%0d", i), rnd_instr(), 4'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
